// File: rtl/dmem_unit.sv
// dmem_unit: synchronous word-RAM data memory for the MEM stage.
// Valid/ready request, one-cycle response pulse, optional 2-beat split of word-crossing accesses.
module dmem_unit #(
    parameter int          XLEN           = 32,
    parameter int          DEPTH_BYTES    = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
    parameter int          ALLOW_MISALIGN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_mode,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int AW    = $clog2(WORDS);
    localparam logic [XLEN:0] DEPTH_L = (XLEN+1)'(DEPTH_BYTES);

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_req_ready;
    logic [XLEN-1:0]   r_off;
    logic [2:0]        r_mode;
    logic              r_we;
    logic [XLEN-1:0]   r_wdata;
    logic              r_err;
    logic              r_split;
    logic [XLEN-1:0]   r_ram_q;
    logic [XLEN-1:0]   r_lo_word;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_err;
    logic [XLEN-1:0]   r_mem [0:WORDS-1];

    logic              w_accept;
    logic [2:0]        w_size;
    logic              w_mode_ok;
    logic [3:0]        w_mask4;
    logic [7:0]        w_mask8;
    logic [1:0]        w_boff;
    logic              w_cross;
    logic [XLEN:0]     w_end;
    logic              w_oor;
    logic              w_store_bad;
    logic              w_err;
    logic [AW-1:0]     w_word0;
    logic [AW-1:0]     w_word1;
    logic [2*XLEN-1:0] w_wdata64;
    logic              w_ram_en;
    logic [AW-1:0]     w_ram_addr;
    logic [3:0]        w_ram_we;
    logic [XLEN-1:0]   w_ram_wdata;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_raw;
    logic [XLEN-1:0]   w_load;

    assign w_accept  = req_valid && r_req_ready;
    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Decode access size and legality of the latched mode
    always_comb begin
        w_size    = 3'd1;
        w_mode_ok = 1'b1;
        case (r_mode)
            MODE_B, MODE_BU: w_size = 3'd1;
            MODE_H, MODE_HU: w_size = 3'd2;
            MODE_W:          w_size = 3'd4;
            default: begin
                w_size    = 3'd1;
                w_mode_ok = 1'b0;
            end
        endcase
    end

    // Byte-enable pattern for the access before lane shifting
    always_comb begin
        w_mask4 = 4'b0001;
        case (w_size)
            3'd1:    w_mask4 = 4'b0001;
            3'd2:    w_mask4 = 4'b0011;
            3'd4:    w_mask4 = 4'b1111;
            default: w_mask4 = 4'b0001;
        endcase
    end

    // Range check is done one bit wider so off+size cannot wrap
    assign w_boff      = r_off[1:0];
    assign w_cross     = ({2'b00, w_boff} + {1'b0, w_size}) > 4'd4;
    assign w_end       = {1'b0, r_off} + {{(XLEN-2){1'b0}}, w_size};
    assign w_oor       = w_end > DEPTH_L;
    assign w_store_bad = r_we && ((r_mode == MODE_BU) || (r_mode == MODE_HU));
    assign w_err       = !w_mode_ok || w_oor || w_store_bad ||
                         (w_cross && (ALLOW_MISALIGN == 0));

    assign w_word0   = r_off[AW+1:2];
    assign w_word1   = w_word0 + {{(AW-1){1'b0}}, 1'b1};
    assign w_mask8   = {4'b0000, w_mask4} << w_boff;
    assign w_wdata64 = {{XLEN{1'b0}}, r_wdata} << {w_boff, 3'b000};

    // Select RAM port controls for the current beat
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_addr  = w_word0;
        w_ram_we    = 4'b0000;
        w_ram_wdata = w_wdata64[XLEN-1:0];
        if (r_state == ST_BEAT0) begin
            w_ram_en = 1'b1;
            w_ram_we = (r_we && !w_err) ? w_mask8[3:0] : 4'b0000;
        end else if (r_state == ST_BEAT1) begin
            w_ram_en    = 1'b1;
            w_ram_addr  = w_word1;
            w_ram_we    = r_we ? w_mask8[7:4] : 4'b0000;
            w_ram_wdata = w_wdata64[2*XLEN-1:XLEN];
        end else begin
            w_ram_en = 1'b0;
        end
    end

    // Word RAM: per-byte writes and registered read; a beat under reset is dropped
    always_ff @(posedge clk) begin
        if (rst_n && w_ram_en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_ram_we[k]) begin
                    r_mem[w_ram_addr][8*k +: 8] <= w_ram_wdata[8*k +: 8];
                end
            end
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = req_valid ? ST_BEAT0 : ST_IDLE;
            ST_BEAT0: begin
                if (w_err) begin
                    w_state_nxt = ST_RESP;
                end else if (w_cross) begin
                    w_state_nxt = ST_BEAT1;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_BEAT1: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Realign the two read words and extend the loaded value
    always_comb begin
        w_lo   = r_split ? r_lo_word : r_ram_q;
        w_hi   = r_ram_q;
        w_raw  = XLEN'({w_hi, w_lo} >> {w_boff, 3'b000});
        w_load = {XLEN{1'b0}};
        case (r_mode)
            MODE_B:  w_load = {{(XLEN-8){w_raw[7]}}, w_raw[7:0]};
            MODE_H:  w_load = {{(XLEN-16){w_raw[15]}}, w_raw[15:0]};
            MODE_W:  w_load = w_raw;
            MODE_BU: w_load = {{(XLEN-8){1'b0}}, w_raw[7:0]};
            MODE_HU: w_load = {{(XLEN-16){1'b0}}, w_raw[15:0]};
            default: w_load = {XLEN{1'b0}};
        endcase
    end

    // Control state, request latch and registered response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_off       <= {XLEN{1'b0}};
            r_mode      <= 3'b000;
            r_we        <= 1'b0;
            r_wdata     <= {XLEN{1'b0}};
            r_err       <= 1'b0;
            r_split     <= 1'b0;
            r_lo_word   <= {XLEN{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {XLEN{1'b0}};
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_off   <= req_addr - BASE_ADDR[XLEN-1:0];
                r_mode  <= req_mode;
                r_we    <= req_we;
                r_wdata <= req_wdata;
            end
            if (r_state == ST_BEAT0) begin
                r_err   <= w_err;
                r_split <= w_cross && !w_err;
            end
            if (r_state == ST_BEAT1) begin
                r_lo_word <= r_ram_q;
            end
            if (r_state == ST_RESP) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= r_err;
                r_rsp_rdata <= (r_err || r_we) ? {XLEN{1'b0}} : w_load;
            end
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: scoreboard of expected responses, two instances
// (split-enabled and misalign-error) sharing one clock.
module tb_dmem_unit;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [2:0]  MB  = 3'b000;
    localparam logic [2:0]  MH  = 3'b001;
    localparam logic [2:0]  MW  = 3'b010;
    localparam logic [2:0]  MBU = 3'b100;
    localparam logic [2:0]  MHU = 3'b101;
    localparam logic [2:0]  MXX = 3'b111;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [2:0]  req_mode  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    exp_t expq  [2][$];
    int   acc_q [2][$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   next_id = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_unit #(.XLEN(32), .DEPTH_BYTES(4096), .BASE_ADDR(BASE), .ALLOW_MISALIGN(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_mode(req_mode[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_unit #(.XLEN(32), .DEPTH_BYTES(4096), .BASE_ADDR(BASE), .ALLOW_MISALIGN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_mode(req_mode[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: pop the scoreboard on every response pulse
    always @(negedge clk) begin
        exp_t e;
        int   a;
        for (int s = 0; s < 2; s++) begin
            if (rsp_valid[s] === 1'b1) begin
                if (expq[s].size() == 0) begin
                    check_val($sformatf("unexpected_rsp_u%0d", s), 32'd1, 32'd0);
                end else begin
                    e = expq[s].pop_front();
                    a = (acc_q[s].size() != 0) ? acc_q[s].pop_front() : -100;
                    check_val($sformatf("rdata_u%0d_#%0d", s, e.id), rsp_rdata[s], e.rdata);
                    check_val($sformatf("err_u%0d_#%0d", s, e.id), {31'd0, rsp_err[s]}, {31'd0, e.err});
                    check_val($sformatf("lat_u%0d_#%0d", s, e.id), cyc - a, e.lat);
                end
            end
        end
    end

    task automatic push_exp(input int s, input logic [31:0] er, input logic ee, input int el);
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        e.lat   = el;
        e.id    = next_id;
        next_id++;
        expq[s].push_back(e);
    endtask

    task automatic set_fields(input int s, input logic we, input logic [2:0] mode,
                              input logic [31:0] off, input logic [31:0] wdata);
        req_we[s]    = we;
        req_mode[s]  = mode;
        req_addr[s]  = BASE + off;
        req_wdata[s] = wdata;
    endtask

    task automatic wait_done(input int s);
        int n = 0;
        while (expq[s].size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val($sformatf("rsp_pending_u%0d", s), expq[s].size(), 32'd0);
        expq[s].delete();
        acc_q[s].delete();
    endtask

    // One request, then wait for its response
    task automatic issue(input int s, input logic we, input logic [2:0] mode, input logic [31:0] off,
                         input logic [31:0] wdata, input logic [31:0] er, input logic ee, input int el);
        int n = 0;
        push_exp(s, er, ee, el);
        set_fields(s, we, mode, off, wdata);
        req_valid[s] = 1'b1;
        while (req_ready[s] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_ready", {31'd0, req_ready[s]}, 32'd1);
        acc_q[s].push_back(cyc + 1);
        @(negedge clk);
        req_valid[s] = 1'b0;
        wait_done(s);
    endtask

    // Back-to-back request with req_valid held; junk fields driven while busy
    task automatic bb_req(input int s, input logic we, input logic [2:0] mode, input logic [31:0] off,
                          input logic [31:0] wdata, input logic [31:0] er, input logic ee, input int el,
                          input int busy);
        int n = 0;
        push_exp(s, er, ee, el);
        set_fields(s, we, mode, off, wdata);
        req_valid[s] = 1'b1;
        acc_q[s].push_back(cyc + 1);
        @(negedge clk);
        set_fields(s, 1'b1, MW, 32'h10, 32'h0BAD_F00D);
        while (req_ready[s] !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_val("busy_cycles", n, busy);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            set_fields(s, 1'b0, MW, 32'h0, 32'h0);
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_val("rst_ready", {31'd0, req_ready[s]}, 32'd1);
            check_val("rst_rsp_valid", {31'd0, rsp_valid[s]}, 32'd0);
            check_val("rst_rdata", rsp_rdata[s], 32'd0);
            check_val("rst_err", {31'd0, rsp_err[s]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned store/load and sub-word extension
        issue(1, 1'b1, MW,  32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        issue(1, 1'b0, MW,  32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
        issue(1, 1'b0, MB,  32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 2);
        issue(1, 1'b0, MBU, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 2);
        issue(1, 1'b0, MH,  32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0, 2);
        issue(1, 1'b0, MHU, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0, 2);
        issue(1, 1'b0, MB,  32'h11, 32'h0, 32'hFFFF_FFBE, 1'b0, 2);

        // Word-crossing split accesses
        issue(1, 1'b1, MW, 32'h20, 32'h0, 32'h0, 1'b0, 2);
        issue(1, 1'b1, MW, 32'h24, 32'h0, 32'h0, 1'b0, 2);
        issue(1, 1'b1, MW, 32'h22, 32'h1122_3344, 32'h0, 1'b0, 3);
        issue(1, 1'b0, MW, 32'h22, 32'h0, 32'h1122_3344, 1'b0, 3);
        issue(1, 1'b0, MW, 32'h20, 32'h0, 32'h3344_0000, 1'b0, 2);
        issue(1, 1'b0, MW, 32'h24, 32'h0, 32'h0000_1122, 1'b0, 2);
        issue(1, 1'b0, MH, 32'h23, 32'h0, 32'h0000_2233, 1'b0, 3);

        // Window edges and illegal requests
        issue(1, 1'b1, MW,  32'hFFC, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
        issue(1, 1'b0, MW,  32'hFFC, 32'h0, 32'hCAFE_F00D, 1'b0, 2);
        issue(1, 1'b0, MB,  32'hFFF, 32'h0, 32'hFFFF_FFCA, 1'b0, 2);
        issue(1, 1'b0, MW,  32'hFFE, 32'h0, 32'h0, 1'b1, 2);
        issue(1, 1'b0, MW,  32'h1000, 32'h0, 32'h0, 1'b1, 2);
        issue(1, 1'b0, MW,  32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 2);
        issue(1, 1'b1, MBU, 32'h10, 32'h0, 32'h0, 1'b1, 2);
        issue(1, 1'b1, MHU, 32'h10, 32'h0, 32'h0, 1'b1, 2);
        issue(1, 1'b0, MXX, 32'h10, 32'h0, 32'h0, 1'b1, 2);
        issue(1, 1'b0, MW,  32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

        // Misalign-error instance
        issue(0, 1'b1, MW,  32'h20, 32'h0102_0304, 32'h0, 1'b0, 2);
        issue(0, 1'b1, MH,  32'h23, 32'h0000_BEEF, 32'h0, 1'b1, 2);
        issue(0, 1'b0, MW,  32'h20, 32'h0, 32'h0102_0304, 1'b0, 2);
        issue(0, 1'b0, MW,  32'h22, 32'h0, 32'h0, 1'b1, 2);
        issue(0, 1'b1, MH,  32'h22, 32'h0000_BEEF, 32'h0, 1'b0, 2);
        issue(0, 1'b0, MW,  32'h20, 32'h0, 32'hBEEF_0304, 1'b0, 2);
        issue(0, 1'b0, MH,  32'h21, 32'h0, 32'hFFFF_EF03, 1'b0, 2);
        issue(0, 1'b0, MW,  32'h1000, 32'h0, 32'h0, 1'b1, 2);
        issue(0, 1'b0, MXX, 32'h20, 32'h0, 32'h0, 1'b1, 2);

        // Back-to-back with req_valid held high
        bb_req(1, 1'b0, MW, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 2);
        bb_req(1, 1'b0, MW, 32'h22, 32'h0, 32'h1122_3344, 1'b0, 3, 3);
        bb_req(1, 1'b1, MB, 32'h11, 32'h0000_0077, 32'h0, 1'b0, 2, 2);
        bb_req(1, 1'b0, MXX, 32'h10, 32'h0, 32'h0, 1'b1, 2, 2);
        bb_req(1, 1'b0, MW, 32'h10, 32'h0, 32'hDEAD_77EF, 1'b0, 2, 2);
        req_valid[1] = 1'b0;
        wait_done(1);

        // Reset during the second beat of a split store
        issue(1, 1'b1, MW, 32'h40, 32'hAAAA_AAAA, 32'h0, 1'b0, 2);
        issue(1, 1'b1, MW, 32'h44, 32'hAAAA_AAAA, 32'h0, 1'b0, 2);
        issue(1, 1'b0, MW, 32'h10, 32'h0, 32'hDEAD_77EF, 1'b0, 2);
        set_fields(1, 1'b1, MW, 32'h42, 32'h5566_7788);
        req_valid[1] = 1'b1;
        check_val("split_rst_ready", {31'd0, req_ready[1]}, 32'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_ready", {31'd0, req_ready[1]}, 32'd1);
        check_val("midrst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        check_val("midrst_rdata", rsp_rdata[1], 32'd0);
        check_val("midrst_err", {31'd0, rsp_err[1]}, 32'd0);
        rst_n = 1'b1;
        acc_q[1].delete();
        repeat (3) @(negedge clk);
        issue(1, 1'b0, MW, 32'h44, 32'h0, 32'hAAAA_AAAA, 1'b0, 2);
        issue(1, 1'b0, MW, 32'h40, 32'h0, 32'h7788_AAAA, 1'b0, 2);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
